// File: rtl/quiz_pkg.sv
// quiz_pkg: shared types and constants for the quiz buzzer round controller
// and the score/display datapath it feeds.
package quiz_pkg;

    // Number of contestants and the width of a contestant index.
    localparam int N_PLAYERS = 4;
    localparam int ID_W      = 2;

    // Round controller states.
    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        LOCKED,
        SCORE,
        TIMEOUT
    } quiz_state_t;

    // Score-update command as seen by the score datapath:
    // we  - one-cycle update strobe
    // id  - contestant to update
    // dec - 1 = subtract one point, 0 = add one point
    typedef struct packed {
        logic            we;
        logic [ID_W-1:0] id;
        logic            dec;
    } score_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating-priority arbiter. Grants one request per cycle
// (combinational one-hot grant plus index), searching from a registered
// pointer. The pointer moves to the slot after adv_id when advance is high.
module rr_arbiter
    import quiz_pkg::*;
#(
    parameter int N = N_PLAYERS,
    parameter int W = ID_W
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    input  logic [W-1:0] adv_id,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_id
);

    logic [W-1:0] ptr;
    int unsigned  idx;
    logic         found;

    // First asserted request at or after the pointer, wrapping around.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = W'(idx);
                found    = 1'b1;
            end
        end
    end

    // Pointer moves to the slot following the last winner.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (adv_id == W'(N - 1)) ? '0 : adv_id + 1'b1;
        end
    end

endmodule

// File: rtl/quiz_arbiter.sv
// quiz_arbiter: round controller for the four-contestant quiz buzzer.
// Synchronises buttons, grants one contestant per round with rotating
// priority, runs the answer countdown and buzzer, and issues one-cycle
// score-update commands.
// Optional feature: define QUIZ_FALSE_START_EN to compile in false-start
// (foul) detection; without it foul is tied to zero.
module quiz_arbiter
    import quiz_pkg::*;
#(
    parameter int N_PLAYERS  = 4,
    parameter int TICK_DIV   = 50_000_000,
    parameter int ANSWER_SEC = 15,
    parameter int BUZZ_CYC   = 12_500_000
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 start,
    input  logic [N_PLAYERS-1:0] buzz,
    input  logic                 judge_add,
    input  logic                 judge_sub,
    output logic                 winner_vld,
    output logic [ID_W-1:0]      winner_id,
    output logic [3:0]           cnt,
    output logic                 score_we,
    output logic [ID_W-1:0]      score_id,
    output logic                 score_dec,
    output logic                 buzzer_n,
    output logic [N_PLAYERS-1:0] foul
);

    localparam int          NR         = N_PLAYERS + 3;
    localparam int          PW         = $clog2(TICK_DIV + 1);
    localparam int          BW         = $clog2(BUZZ_CYC + 1);
    localparam logic [3:0]  CNT_LOAD   = 4'(ANSWER_SEC);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BUZZ_LOAD = BW'(BUZZ_CYC - 1);

    quiz_state_t          state;
    score_cmd_t           cmd_q;
    logic [PW-1:0]        presc;
    logic [BW-1:0]        buzz_cnt;

    logic [NR-1:0]        raw, s1, s2, s3, edges;
    logic [N_PLAYERS-1:0] buzz_edge, elig, arb_req, arb_gnt;
    logic                 start_edge, add_edge, sub_edge;
    logic [ID_W-1:0]      arb_id;
    logic                 grant_fire, timeout_fire, buzz_req, arb_adv;

    assign raw        = {judge_sub, judge_add, start, buzz};
    assign edges      = s2 & ~s3;
    assign buzz_edge  = edges[N_PLAYERS-1:0];
    assign start_edge = edges[N_PLAYERS];
    assign add_edge   = edges[N_PLAYERS+1];
    assign sub_edge   = edges[N_PLAYERS+2];

    // Two-flop synchroniser plus one delay stage for rising-edge detection.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            s3 <= s2;
        end
    end

`ifdef QUIZ_FALSE_START_EN
    logic [N_PLAYERS-1:0] foul_q;
    logic                 leave_locked;

    assign leave_locked = (state == LOCKED) && ((cnt == '0) || add_edge || sub_edge);

    // Buzzes in IDLE mark a false start; flags clear once the round is decided.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            foul_q <= '0;
        end else if (state == IDLE) begin
            foul_q <= foul_q | buzz_edge;
        end else if (leave_locked) begin
            foul_q <= '0;
        end
    end

    assign foul = foul_q;
    assign elig = buzz_edge & ~foul_q;
`else
    assign foul = '0;
    assign elig = buzz_edge;
`endif

    assign arb_req      = (state == ARMED) ? elig : '0;
    assign grant_fire   = |arb_gnt;
    assign timeout_fire = (state == LOCKED) && (cnt == '0);
    assign buzz_req     = grant_fire || timeout_fire;
    assign arb_adv      = (state == SCORE) || (state == TIMEOUT);

    rr_arbiter #(
        .N (N_PLAYERS),
        .W (ID_W)
    ) u_rr_arbiter (
        .clk     (clk),
        .clr_n   (clr_n),
        .req     (arb_req),
        .advance (arb_adv),
        .adv_id  (winner_id),
        .gnt     (arb_gnt),
        .gnt_id  (arb_id)
    );

    // Round FSM with countdown prescaler and registered score command.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= IDLE;
            winner_vld <= 1'b0;
            winner_id  <= '0;
            cnt        <= CNT_LOAD;
            presc      <= '0;
            cmd_q      <= '0;
        end else begin
            cmd_q.we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) state <= ARMED;
                end
                ARMED: begin
                    if (grant_fire) begin
                        state      <= LOCKED;
                        winner_vld <= 1'b1;
                        winner_id  <= arb_id;
                        cnt        <= CNT_LOAD;
                        presc      <= '0;
                    end
                end
                LOCKED: begin
                    if (cnt == '0) begin
                        state <= TIMEOUT;
                    end else if (add_edge) begin
                        state     <= SCORE;
                        cmd_q.dec <= 1'b0;
                    end else if (sub_edge) begin
                        state     <= SCORE;
                        cmd_q.dec <= 1'b1;
                    end else if (presc == PRESC_MAX) begin
                        presc <= '0;
                        cnt   <= cnt - 1'b1;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                SCORE: begin
                    cmd_q.we   <= 1'b1;
                    cmd_q.id   <= winner_id;
                    winner_vld <= 1'b0;
                    cnt        <= CNT_LOAD;
                    state      <= IDLE;
                end
                TIMEOUT: begin
                    winner_vld <= 1'b0;
                    cnt        <= CNT_LOAD;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign score_we  = cmd_q.we;
    assign score_id  = cmd_q.id;
    assign score_dec = cmd_q.dec;

    // Buzzer pulse timer; a new request restarts the full pulse length.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            buzz_cnt <= '0;
            buzzer_n <= 1'b1;
        end else if (buzz_req) begin
            buzz_cnt <= BUZZ_LOAD;
            buzzer_n <= 1'b0;
        end else if (buzz_cnt != '0) begin
            buzz_cnt <= buzz_cnt - 1'b1;
        end else begin
            buzzer_n <= 1'b1;
        end
    end

endmodule

// File: tb/tb_quiz_arbiter.sv
// tb_quiz_arbiter: randomized self-checking bench for quiz_arbiter.
// Expected winners, countdown values and score commands come from a
// round-level model (priority pointer, foul mask, latency arithmetic).
module tb_quiz_arbiter;

    localparam int TICK = 4;
    localparam int ANS  = 15;
    localparam int BZ   = 6;

    logic       clk = 1'b0;
    logic       clr_n, start, judge_add, judge_sub;
    logic [3:0] buzz;
    logic       winner_vld, score_we, score_dec, buzzer_n;
    logic [1:0] winner_id, score_id;
    logic [3:0] cnt, foul;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         mptr     = 0;
    logic [3:0] mfoul    = 4'b0000;
    int         exp_sw   = 0;
    int         sw_seen  = 0;
    int         sw_double = 0;
    logic       sw_prev  = 1'b0;
    int         w;

    quiz_arbiter #(
        .N_PLAYERS  (4),
        .TICK_DIV   (TICK),
        .ANSWER_SEC (ANS),
        .BUZZ_CYC   (BZ)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .start      (start),
        .buzz       (buzz),
        .judge_add  (judge_add),
        .judge_sub  (judge_sub),
        .winner_vld (winner_vld),
        .winner_id  (winner_id),
        .cnt        (cnt),
        .score_we   (score_we),
        .score_id   (score_id),
        .score_dec  (score_dec),
        .buzzer_n   (buzzer_n),
        .foul       (foul)
    );

    always #5 clk = ~clk;

    // Score strobe monitor: counts pulses and back-to-back highs.
    always @(negedge clk) begin
        if (score_we === 1'b1) begin
            sw_seen++;
            if (sw_prev) sw_double++;
        end
        sw_prev = (score_we === 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Rotating priority: first pressed index at or after the pointer.
    function automatic int pick(input logic [3:0] mask, input int ptr);
        for (int i = 0; i < 4; i++) begin
            if (mask[(ptr + i) % 4]) return (ptr + i) % 4;
        end
        return -1;
    endfunction

    task automatic check_reset(input string pfx);
        check({pfx, "_vld"},   winner_vld, 0);
        check({pfx, "_id"},    winner_id,  0);
        check({pfx, "_cnt"},   cnt,        ANS);
        check({pfx, "_we"},    score_we,   0);
        check({pfx, "_sid"},   score_id,   0);
        check({pfx, "_dec"},   score_dec,  0);
        check({pfx, "_bz"},    buzzer_n,   1);
        check({pfx, "_foul"},  foul,       0);
    endtask

    task automatic start_round();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        check("armed_vld", winner_vld, 0);
        check("armed_cnt", cnt, ANS);
    endtask

    task automatic grant(input logic [3:0] mask, output int wid);
        wid  = pick(mask & ~mfoul, mptr);
        buzz = mask;
        tick(2);
        check("grant_early", winner_vld, 0);
        tick(1);
        check("grant_vld", winner_vld, 1);
        check("grant_id",  winner_id,  wid);
        check("grant_cnt", cnt,        ANS);
        check("grant_bz",  buzzer_n,   0);
        buzz = 4'b0000;
    endtask

    // action: 0-2 add, 3-5 sub, 6 both keys, 7 let the countdown expire
    task automatic do_round(input logic [3:0] mask, input int action);
        int wid;
        int t;
        int n;
        start_round();
        grant(mask, wid);
        n = 0;
        while (buzzer_n === 1'b0 && n < 100) begin
            n++;
            tick(1);
        end
        check("buzz_len", n, BZ);
        t = n;
        buzz = 4'b1111;
        tick(3);
        t += 3;
        buzz = 4'b0000;
        check("one_grant_id",  winner_id, wid);
        check("one_grant_vld", winner_vld, 1);
        check("cnt_mid", cnt, ANS - t / TICK);
        if (action == 7) begin
            while (t < ANS * TICK) begin
                tick(1);
                t++;
                check("cnt_down", cnt, ANS - t / TICK);
            end
            tick(1);
            check("to_vld", winner_vld, 1);
            check("to_cnt", cnt, 0);
            n = 0;
            while (buzzer_n === 1'b0 && n < 100) begin
                n++;
                tick(1);
            end
            check("to_buzz_len", n, BZ);
            check("to_idle_vld", winner_vld, 0);
            check("to_idle_cnt", cnt, ANS);
        end else begin
            judge_add = (action <= 2) || (action == 6);
            judge_sub = (action >= 3);
            tick(3);
            check("sw_early", score_we, 0);
            tick(1);
            check("sw_pulse", score_we,  1);
            check("sw_id",    score_id,  wid);
            check("sw_dec",   score_dec, (action >= 3 && action <= 5) ? 1 : 0);
            check("sw_vld",   winner_vld, 0);
            check("sw_cnt",   cnt, ANS);
            exp_sw++;
            tick(1);
            check("sw_after", score_we, 0);
            judge_add = 1'b0;
            judge_sub = 1'b0;
        end
        mptr  = (wid + 1) % 4;
        mfoul = 4'b0000;
        tick(2);
    endtask

    initial begin
        clr_n     = 1'b0;
        start     = 1'b0;
        judge_add = 1'b0;
        judge_sub = 1'b0;
        buzz      = 4'b0000;
        tick(2);
        check_reset("rst");
        clr_n = 1'b1;
        tick(2);

        do_round(4'b0011, 0);
        do_round(4'b0011, 6);
        do_round(4'b0100, 3);
        do_round(4'b1000, 7);

        for (int r = 0; r < 20; r++) begin
            do_round(4'($urandom_range(1, 15)), int'($urandom_range(0, 7)));
        end

        // Buzz while idle, then a round in which player 3 also presses.
        buzz = 4'b1000;
        tick(1);
        buzz = 4'b0000;
        tick(3);
`ifdef QUIZ_FALSE_START_EN
        mfoul = 4'b1000;
`endif
        check("idle_foul", foul, mfoul);
        check("idle_vld", winner_vld, 0);
        start_round();
`ifdef QUIZ_FALSE_START_EN
        buzz = 4'b1000;
        tick(1);
        buzz = 4'b0000;
        tick(3);
        check("foul_ignored", winner_vld, 0);
`endif
        grant(4'b1010, w);
        tick(1);
        check("pre_clr_bz", buzzer_n, 0);

        // Reset in the middle of a round with the buzzer sounding.
        clr_n = 1'b0;
        #1;
        check_reset("midclr");
        tick(2);
        clr_n = 1'b1;
        tick(2);
        check_reset("postclr");
        mptr  = 0;
        mfoul = 4'b0000;

        do_round(4'b0011, 1);

        check("sw_count",  sw_seen,   exp_sw);
        check("sw_double", sw_double, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/quiz_arbiter.md
# quiz_arbiter

Round controller for the four-contestant quiz buzzer system. Synchronises the contestant buttons and grants the answer to exactly one contestant per round, using rotating priority for simultaneous presses. Runs the per-answer countdown, drives the buzzer, and turns judge add/subtract keys into single-cycle score-update commands for the score/display datapath.

## Interface
- `N_PLAYERS`, 4: number of contestants; the player ID width is 2 bits.
- `TICK_DIV`, 50_000_000: `clk` cycles per countdown second.
- `ANSWER_SEC`, 15: countdown load value; must be in the range 1..15.
- `BUZZ_CYC`, 12_500_000: buzzer pulse length in `clk` cycles.
- `clk`  in  1  system clock.
- `clr_n`  in  1  reset; asynchronous assert, active-low.
- `start`  in  1  host key; opens a round. Level input, edge-detected internally.
- `buzz`  in  N_PLAYERS  raw contestant buttons, active-high, asynchronous.
- `judge_add`  in  1  judge "correct" key, edge-detected.
- `judge_sub`  in  1  judge "wrong" key, edge-detected.
- `winner_vld`  out  1  a contestant holds the floor.
- `winner_id`  out  2  index of the granted contestant.
- `cnt`  out  4  countdown seconds remaining; drives the display.
- `score_we`  out  1  one-cycle score-update strobe.
- `score_id`  out  2  contestant to update.
- `score_dec`  out  1  1 = subtract one point, 0 = add one point.
- `buzzer_n`  out  1  buzzer drive, active-low.
- `foul`  out  N_PLAYERS  sticky false-start flags; present only when false-start detection is compiled in, otherwise tied to 0.

## Operation
- All button inputs pass through a 2-flop synchroniser, then rising-edge detection. Logic reacts only to edges.
- States:
  - **IDLE**: buzzes are ignored, except for foul detection. A `start` edge moves to ARMED.
  - **ARMED**: in a cycle with one or more eligible buzz edges, the rotating-priority arbiter grants one contestant. The search starts at the index after the previous winner (index 0 after reset). The FSM then moves to LOCKED.
  - **LOCKED**:
    - `winner_vld`=1; `cnt` loads `ANSWER_SEC`; the prescaler clears; a `BUZZ_CYC` buzzer pulse starts.
    - Each full `TICK_DIV` period decrements `cnt`.
    - A `judge_add` edge moves to SCORE with `score_dec`=0. A `judge_sub` edge moves to SCORE with `score_dec`=1. If both edges arrive in the same cycle, add wins.
    - `cnt` reaching 0 moves to TIMEOUT.
  - **SCORE**: pulses `score_we` for one cycle with `score_id`=`winner_id`, updates the priority pointer, then goes to IDLE.
  - **TIMEOUT**: starts a `BUZZ_CYC` buzzer pulse, issues no score change, updates the priority pointer, then goes to IDLE.
- In IDLE and ARMED, `cnt` shows `ANSWER_SEC`.
- A `start` edge in LOCKED, SCORE or TIMEOUT is ignored.
- The buzzer pulse counter runs independently of the FSM. A new pulse request while one is active restarts the pulse to its full length.
- Score saturation belongs to the score datapath, not this block.

## Timing
- Reset values:
  - FSM in IDLE; `winner_vld`=0; `winner_id`=0; `cnt`=`ANSWER_SEC`.
  - `score_we`=0; `score_id`=0; `score_dec`=0.
  - `buzzer_n`=1; `foul`=0; priority pointer=0.
- Latency:
  - Buzz pin edge to synchronised edge: 2 cycles. Grant (`winner_vld` high) follows 1 cycle after that, for 3 cycles total.
  - Judge key edge to `score_we`: 4 cycles (2 sync, 1 edge detect, 1 state).
- Countdown: the first decrement occurs exactly `TICK_DIV` cycles after entry to LOCKED. TIMEOUT is entered in the cycle after `cnt` becomes 0.
- Simultaneous buzz edges resolve in a single cycle; there is never more than one grant per round.
- `clr_n` asserted mid-round returns every register to its reset value immediately, including an active buzzer pulse. No `score_we` is issued.
- `score_we` is never high for two consecutive cycles.

## Configuration
- `QUIZ_FALSE_START_EN` defined:
  - A buzz edge in IDLE sets that player's `foul` bit.
  - A fouled player is ineligible in the next ARMED state; its bit clears when that round leaves LOCKED or TIMEOUT.
  - If every player is fouled, ARMED waits until `clr_n`.
- `QUIZ_FALSE_START_EN` undefined: no foul registers; `foul`=0; every buzz edge in IDLE is ignored.

## Structure
- `quiz_pkg` holds:
  - state enum (IDLE, ARMED, LOCKED, SCORE, TIMEOUT);
  - `N_PLAYERS`;
  - ID-width constant;
  - the score-command field layout shared with the score datapath.
- Sub-module `rr_arbiter`:
  - combinational rotating-priority one-hot grant over an eligible request mask, plus a registered pointer;
  - pointer updates on an `advance` input.
- The FSM, prescaler, buzzer counter and synchronisers stay in `quiz_arbiter`.

## Test plan
- Reset, `start`, then `buzz`=4'b0100 → `winner_vld`=1, `winner_id`=2, `cnt`=15, `buzzer_n` low for `BUZZ_CYC` cycles.
- Round one: `buzz`=4'b0011 in the same cycle → `winner_id`=0. After `judge_add` and a new `start`, `buzz`=4'b0011 again → `winner_id`=1 (rotation).
- Winner 2 with `judge_sub` → a single `score_we` pulse with `score_id`=2, `score_dec`=1; FSM returns to IDLE.
- LOCKED with no judge input (`TICK_DIV`=4 in the bench) → `cnt` counts 15..0 every 4 cycles, then a TIMEOUT buzzer pulse, no `score_we`, IDLE.
- `judge_add` and `judge_sub` edges in the same cycle → `score_dec`=0.
- `QUIZ_FALSE_START_EN` defined: `buzz` on player 3 in IDLE → `foul`=4'b1000. After `start`, player 3's buzz is ignored; player 1's buzz → `winner_id`=1. `clr_n` low in LOCKED → all outputs return to reset values.
